// File: rtl/skel_frame_engine_if.sv
// skel_frame_engine_if: stream, control and status bundle for the thinning engine.
// slave = engine side, master = pixel source / sink side.
interface skel_frame_engine_if #(
  parameter int PIXEL_W = 8,
  parameter int PASS_W  = 8
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [PIXEL_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [PIXEL_W-1:0] out_data;
  logic               busy;
  logic               done;
  logic [PASS_W-1:0]  pass_count;
  logic               limit_hit;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, pass_count, limit_hit
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, pass_count, limit_hit
  );
endinterface

// File: rtl/skel_frame_engine.sv
// skel_frame_engine: loads a binary frame, runs Zhang-Suen thinning until a
// pass deletes nothing, then streams the skeleton out in raster order.
// Optional macro SKEL_PASS_LIMIT_EN: stop thinning after MAX_PASSES passes
// and flag it on limit_hit; without it limit_hit stays 0.
module skel_frame_engine #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int PIXEL_W    = 8,
  parameter int THRESH     = 128,
  parameter int PASS_W     = 8,
  parameter int MAX_PASSES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  skel_frame_engine_if.slave bus
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = (N > 1)      ? $clog2(N)      : 1;
  localparam int CW = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
`ifdef SKEL_PASS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_APPLY, S_EVAL, S_OUT} state_t;

  state_t              r_state, w_next;
  logic [N-1:0]        r_frame, r_mark;
  logic [AW-1:0]       r_addr, w_addr_nxt;
  logic [CW-1:0]       r_col, w_col_nxt;
  logic [RW-1:0]       r_row, w_row_nxt;
  logic [3:0]          r_step;
  logic [7:0]          r_nbv;
  logic                r_sub, r_chg, r_limit, r_done;
  logic [PASS_W-1:0]   r_pass, w_pass_nxt;

  logic                w_last, w_pix, w_pix_done, w_limit_reach;
  logic                w_in_ready, w_out_valid, w_busy;
  int                  w_dr, w_dc, w_nr, w_nc;
  logic [AW-1:0]       w_nidx;
  logic                w_nb_in;
  logic [3:0]          w_b, w_a;
  logic                w_sub_ok, w_mark;

  assign w_last     = (r_addr == AW'(N - 1));
  assign w_pix      = r_frame[r_addr];
  // Background pixels finish in their first cycle; foreground ones after the evaluate step.
  assign w_pix_done = ((r_step == 4'd0) && !w_pix) || (r_step == 4'd8);
  assign w_pass_nxt = (&r_pass) ? r_pass : r_pass + 1'b1;
  assign w_limit_reach = LIMIT_EN && (w_pass_nxt == PASS_W'(MAX_PASSES));

  // Raster address successor, wrapping to 0 after the last pixel.
  always_comb begin
    w_addr_nxt = w_last ? '0 : r_addr + 1'b1;
    w_col_nxt  = r_col + 1'b1;
    w_row_nxt  = r_row;
    if (r_col == CW'(WIDTH - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + 1'b1;
    end
  end

  // Neighbour fetch: step 0..7 walks P2..P9 clockwise from north; off-frame reads 0.
  always_comb begin
    w_dr = 0;
    w_dc = 0;
    case (r_step[2:0])
      3'd0: begin w_dr = -1; w_dc =  0; end
      3'd1: begin w_dr = -1; w_dc =  1; end
      3'd2: begin w_dr =  0; w_dc =  1; end
      3'd3: begin w_dr =  1; w_dc =  1; end
      3'd4: begin w_dr =  1; w_dc =  0; end
      3'd5: begin w_dr =  1; w_dc = -1; end
      3'd6: begin w_dr =  0; w_dc = -1; end
      default: begin w_dr = -1; w_dc = -1; end
    endcase
    w_nr    = int'(r_row) + w_dr;
    w_nc    = int'(r_col) + w_dc;
    w_nidx  = AW'(w_nr * WIDTH + w_nc);
    w_nb_in = 1'b0;
    if (w_nr >= 0 && w_nr < HEIGHT && w_nc >= 0 && w_nc < WIDTH)
      w_nb_in = r_frame[w_nidx];
  end

  // Deletion test: B = neighbour count, A = 0->1 transitions around P2..P9,P2.
  always_comb begin
    w_b = '0;
    w_a = '0;
    for (int i = 0; i < 8; i++) begin
      w_b = w_b + {3'b000, r_nbv[i]};
      if (!r_nbv[i] && r_nbv[(i + 1) % 8]) w_a = w_a + 4'd1;
    end
    if (r_sub)
      w_sub_ok = !(r_nbv[0] & r_nbv[2] & r_nbv[6]) && !(r_nbv[0] & r_nbv[4] & r_nbv[6]);
    else
      w_sub_ok = !(r_nbv[0] & r_nbv[2] & r_nbv[4]) && !(r_nbv[2] & r_nbv[4] & r_nbv[6]);
    w_mark = (w_b >= 4'd2) && (w_b <= 4'd6) && (w_a == 4'd1) && w_sub_ok;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) w_next = S_SCAN;
      end
      S_SCAN:  if (w_pix_done && w_last) w_next = S_APPLY;
      S_APPLY: if (w_last) w_next = r_sub ? S_EVAL : S_SCAN;
      S_EVAL: begin
        if (!r_chg || w_limit_reach) w_next = S_OUT;
        else                         w_next = S_SCAN;
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: frame/mark buffers, address walk, pass bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_mark  <= '0;
      r_addr  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_step  <= '0;
      r_nbv   <= '0;
      r_sub   <= 1'b0;
      r_chg   <= 1'b0;
      r_limit <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          r_col  <= '0;
          r_row  <= '0;
          r_step <= '0;
          r_sub  <= 1'b0;
          r_chg  <= 1'b0;
          // Status from the previous frame stays visible until the next start.
          if (bus.start) begin
            r_pass  <= '0;
            r_limit <= 1'b0;
          end
        end
        S_LOAD: if (bus.in_valid) begin
          r_frame[r_addr] <= (bus.in_data >= PIXEL_W'(THRESH));
          r_mark[r_addr]  <= 1'b0;
          r_addr <= w_addr_nxt;
          r_col  <= w_col_nxt;
          r_row  <= w_row_nxt;
        end
        S_SCAN: begin
          if (r_step == 4'd8 && w_mark) begin
            r_mark[r_addr] <= 1'b1;
            r_chg          <= 1'b1;
          end
          if (w_pix_done) begin
            r_step <= '0;
            r_addr <= w_addr_nxt;
            r_col  <= w_col_nxt;
            r_row  <= w_row_nxt;
          end else begin
            r_nbv[r_step[2:0]] <= w_nb_in;
            r_step <= r_step + 4'd1;
          end
        end
        S_APPLY: begin
          // Deletions land only here, so a subiteration sees a frozen frame.
          if (r_mark[r_addr]) r_frame[r_addr] <= 1'b0;
          r_mark[r_addr] <= 1'b0;
          r_addr <= w_addr_nxt;
          r_col  <= w_col_nxt;
          r_row  <= w_row_nxt;
          if (w_last && !r_sub) r_sub <= 1'b1;
        end
        S_EVAL: begin
          r_pass <= w_pass_nxt;
          if (r_chg) begin
            r_chg <= 1'b0;
            r_sub <= 1'b0;
            if (w_limit_reach) r_limit <= 1'b1;
          end
        end
        S_OUT: if (bus.out_ready) begin
          r_addr <= w_addr_nxt;
          r_col  <= w_col_nxt;
          r_row  <= w_row_nxt;
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = {PIXEL_W{w_pix}};
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.pass_count = r_pass;
  assign bus.limit_hit  = r_limit;
endmodule

// File: tb/tb_skel_frame_engine.sv
// tb_skel_frame_engine: table of 8x8 frames with hand-derived skeletons,
// plus a mid-load reset sequence and an output-stall sequence.
module tb_skel_frame_engine;
  localparam int N = 64;
`ifdef SKEL_PASS_LIMIT_EN
  localparam int MP  = 1;
  localparam bit LIM = 1'b1;
`else
  localparam int MP  = 16;
  localparam bit LIM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  skel_frame_engine_if #(.PIXEL_W(8), .PASS_W(8)) bus ();

  skel_frame_engine #(
    .WIDTH(8), .HEIGHT(8), .PIXEL_W(8), .THRESH(128), .PASS_W(8), .MAX_PASSES(MP)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [63:0] img;
    logic [63:0] exp;
    logic [7:0]  pass;
    logic        lim;
    bit          stall;
    bit          noise;
  } vec_t;

  vec_t vecs[5];
  int   n_cmp, n_bad;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  // Present pixels of img in raster order; threshold-edge grey levels used on purpose.
  task automatic load(input logic [63:0] img, input int cnt);
    int k = 0;
    int cyc = 0;
    while (k < cnt && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b1;
      bus.in_data  = img[k] ? 8'(128 + (k % 2) * 127) : 8'(127 - (k % 3) * 60);
      if (bus.in_ready) k++;
    end
    @(negedge clk) bus.in_valid = 1'b0;
    if (k != cnt) chk("load_timeout", 64'(k), 64'(cnt));
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] got = '0;
    int k = 0, cyc = 0, done_cnt = 0;
    bit held_v = 1'b0, fmt_ok = 1'b1, rdy;
    logic [7:0] held_d = '0;
    pulse_start();
    load(v.img, N);
    while (k < N && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) done_cnt++;
      rdy = v.stall ? (cyc % 2 == 1) : 1'b1;
      if (bus.out_valid) begin
        if (held_v) chk({v.name, "/stall_hold"}, 64'(bus.out_data), 64'(held_d));
        if (bus.out_data != 8'h00 && bus.out_data != 8'hFF) fmt_ok = 1'b0;
        if (rdy) begin
          got[k] = bus.out_data[0];
          k++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = bus.out_data;
        end
      end
      bus.out_ready = rdy;
      if (v.noise) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.start    = (k < N - 2) && (cyc % 7 == 3);
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (k != N) chk({v.name, "/out_timeout"}, 64'(k), 64'(N));
    repeat (3) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (bus.done) done_cnt++;
    end
    chk({v.name, "/frame"},      got, v.exp);
    chk({v.name, "/pass_count"}, 64'(bus.pass_count), 64'(v.pass));
    chk({v.name, "/limit_hit"},  64'(bus.limit_hit), 64'(v.lim));
    chk({v.name, "/done_pulses"}, 64'(done_cnt), 64'd1);
    chk({v.name, "/busy_after"}, 64'(bus.busy), 64'd0);
    chk({v.name, "/data_format"}, 64'(fmt_ok), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{"zero",   64'h0, 64'h0, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"single", 64'h1 << 36, 64'h1 << 36, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"block",  (64'h7 << 18) | (64'h7 << 26) | (64'h7 << 34), 64'h1 << 27,
                LIM ? 8'd1 : 8'd2, LIM, 1'b0, 1'b0};
    vecs[3] = '{"hline",  64'h3F << 25, 64'h3F << 25, 8'd1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"block_stall", (64'h7 << 18) | (64'h7 << 26) | (64'h7 << 34), 64'h1 << 27,
                LIM ? 8'd1 : 8'd2, LIM, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst/busy",       64'(bus.busy),       64'd0);
    chk("rst/in_ready",   64'(bus.in_ready),   64'd0);
    chk("rst/out_valid",  64'(bus.out_valid),  64'd0);
    chk("rst/done",       64'(bus.done),       64'd0);
    chk("rst/pass_count", 64'(bus.pass_count), 64'd0);
    chk("rst/limit_hit",  64'(bus.limit_hit),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort a load after 10 pixels.
    pulse_start();
    load(64'hFFFF_FFFF_FFFF_FFFF, 10);
    chk("midload/busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midload/busy_in_rst",     64'(bus.busy),     64'd0);
    chk("midload/in_ready_in_rst", 64'(bus.in_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (3) @(negedge clk);
    chk("midload/busy_after",      64'(bus.busy),      64'd0);
    chk("midload/in_ready_after",  64'(bus.in_ready),  64'd0);
    chk("midload/out_valid_after", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/skel_frame_engine.md
Name: skel_frame_engine

Overview:
- Parametrised successor to the single-mask image controller.
- Owns a WIDTH x HEIGHT binary frame buffer and a 1-bit-per-pixel deletion-mark buffer.
- Loads a raster-order pixel stream, then runs iterative Zhang-Suen thinning (two subiterations per pass) until a pass deletes nothing, then streams the skeleton out.
- Sits between the pixel source and downstream corner/feature logic. Uses valid/ready on both sides.

Parameters:
- WIDTH, 8: frame columns.
- HEIGHT, 8: frame rows.
- PIXEL_W, 8: input/output pixel width.
- THRESH, 128: input pixel >= THRESH is stored as foreground (1).
- PASS_W, 8: pass counter width.
- MAX_PASSES, 16: pass limit; used only with SKEL_PASS_LIMIT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  PIXEL_W  input pixel, raster order, row 0 col 0 first.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accept.
- out_data  out  PIXEL_W  0 or all-ones.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last output pixel is accepted.
- pass_count  out  PASS_W  passes executed in the current frame.
- limit_hit  out  1  with SKEL_PASS_LIMIT_EN: set if the limit ended thinning; otherwise tied 0.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - in_ready, out_valid, busy, done, limit_hit, pass_count = 0.
  - Frame and mark buffer contents are don't-care.
  - Reset mid-operation aborts immediately. No partial output continues after release.
- FSM states: IDLE -> LOAD -> SCAN -> APPLY -> (SCAN | EVAL) -> OUT -> IDLE.
- IDLE:
  - start=1 -> LOAD.
  - Clears the pixel address, pass_count, limit_hit, subiteration bit and pass-change flag.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes (in_data>=THRESH) to the current address, then increments it.
  - After the WIDTH*HEIGHT-th accept -> SCAN, with subiter=0 and address=0.
- SCAN (per pixel P1, raster order):
  - Background pixel: 1 cycle, no mark.
  - Foreground pixel: 8 cycles, reading one neighbour per cycle in order P2=N, P3=NE, P4=E, P5=SE, P6=S, P7=SW, P8=W, P9=NW. Out-of-frame neighbours read as 0.
  - Then 1 evaluate cycle. Compute B = count of ones in P2..P9, and A = number of 0->1 transitions in the cyclic sequence P2..P9,P2.
  - Mark the pixel iff 2<=B<=6, A==1, and:
    - subiter 0: P2&P4&P6==0 and P4&P6&P8==0.
    - subiter 1: P2&P4&P8==0 and P2&P6&P8==0.
  - Any mark sets the pass-change flag.
  - After the last pixel -> APPLY.
- APPLY:
  - 1 cycle per pixel. A marked pixel is cleared in the frame buffer, and every mark is cleared.
  - Deletions therefore never affect decisions within the same subiteration.
  - At the end: if subiter=0, set subiter=1 -> SCAN. If subiter=1 -> EVAL.
- EVAL:
  - 1 cycle. pass_count++ (saturating at 2^PASS_W-1).
  - If the pass-change flag is 0 -> OUT. Otherwise clear the flag, set subiter=0 -> SCAN.
- OUT:
  - Raster readout. out_valid=1 with out_data={PIXEL_W{bit}}.
  - out_data is stable while out_valid&~out_ready.
  - Address advances only on out_valid&out_ready.
  - On the last accept: pulse done, -> IDLE. pass_count and limit_hit hold until the next start.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored.
- Address counters wrap to 0 at WIDTH*HEIGHT.

Optional Feature:
- SKEL_PASS_LIMIT_EN defined: in EVAL, if the pass-change flag is 1 and pass_count (after increment) == MAX_PASSES, set limit_hit=1 and go to OUT with the partially thinned frame.
- Not defined: thinning runs until convergence, and limit_hit is constant 0.

Test Plan:
- Reset held low during LOAD after 10 pixels, then released -> IDLE, busy=0, in_ready=0. A fresh start then reloads all 64 pixels.
- 8x8 all-zero frame -> pass_count=1, 64 output pixels all 0x00, done pulses once after the 64th accept.
- 8x8 frame with a single 255 at (4,4) -> B=0, no deletion, pass_count=1, output identical to input.
- 8x8 frame with a 3x3 block of 255 at rows 2-4, cols 2-4 -> subiter 0 leaves (2,3),(3,2),(3,3); subiter 1 leaves (3,3). pass_count=2, output is 0xFF only at (3,3).
- Same block, out_ready toggling 1-0-1-0 -> out_data stable during stalls, exactly 64 accepts, no pixel repeated or skipped.
- SKEL_PASS_LIMIT_EN with MAX_PASSES=1, same block -> limit_hit=1, pass_count=1, output is 0xFF only at (3,3).
